// File: rtl/chan_mux_pkg.sv
// Shared definitions for the round-robin/fixed channel multiplexer.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for a channel count; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_mux_rr_if.sv
// Handshake bundle between producers/consumer and the channel multiplexer.
interface chan_mux_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    import chan_mux_pkg::*;

    localparam int SEL_W = idx_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_channel;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );

    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );

endinterface

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                enable,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                any_gnt
);

    localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] cand_s;
    logic             hit_s;

    // Walk channels in rotated order, latching onto the first valid request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s   = {1'b0, ptr} + (SEL_W+1)'(k);
            cand_s  = (sum_s >= CH_W) ? SEL_W'(sum_s - CH_W) : SEL_W'(sum_s);
            hit_s   = enable && !any_gnt && req[cand_s];
            gnt[cand_s] = gnt[cand_s] | hit_s;
            gnt_idx = hit_s ? cand_s : gnt_idx;
            any_gnt = any_gnt | hit_s;
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered multiplexer with fixed-select or round-robin arbitration.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = idx_width(CHANNELS)
) (
    input  logic          clk,
    input  logic          reset_n,
    chan_mux_rr_if.slave  bus
);

    localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_channel_q, out_channel_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                load_en_s;
    logic                sel_ok_s;
    logic                fix_gnt_s;
    logic [CHANNELS-1:0] rr_gnt_s;
    logic [SEL_W-1:0]    rr_idx_s;
    logic                rr_any_s;
    logic [CHANNELS-1:0] gnt_vec_s;
    logic [SEL_W-1:0]    gnt_idx_s;
    logic                any_gnt_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [SEL_W:0]      ptr_inc_s;

    assign load_en_s = !out_valid_q || bus.out_ready;
    assign sel_ok_s  = ({1'b0, bus.select} < CH_W);
    assign fix_gnt_s = load_en_s && sel_ok_s && bus.in_valid[bus.select];

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .enable  (load_en_s),
        .gnt     (rr_gnt_s),
        .gnt_idx (rr_idx_s),
        .any_gnt (rr_any_s)
    );

    // Pick the grant source according to the current mode.
    always_comb begin
        gnt_vec_s = '0;
        gnt_idx_s = '0;
        any_gnt_s = 1'b0;
        if (bus.mode == MODE_RR) begin
            gnt_vec_s = rr_gnt_s;
            gnt_idx_s = rr_idx_s;
            any_gnt_s = rr_any_s;
        end else begin
            gnt_vec_s = fix_gnt_s ? (CHANNELS'(1'b1) << bus.select) : '0;
            gnt_idx_s = bus.select;
            any_gnt_s = fix_gnt_s;
        end
    end

    // In reset nothing may be accepted, even though the empty register would allow it.
    assign bus.in_ready = reset_n ? gnt_vec_s : '0;

    // One-hot AND-OR data select keeps the data path free of wide index arithmetic.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_data_s = sel_data_s | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{gnt_vec_s[k]}});
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        rr_ptr_d      = rr_ptr_q;
        ptr_inc_s     = {1'b0, rr_idx_s} + (SEL_W+1)'(1'b1);
        if (any_gnt_s) begin
            out_data_d    = sel_data_s;
            out_channel_d = gnt_idx_s;
            out_valid_d   = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d   = 1'b0;
        end else begin
            out_valid_d   = out_valid_q;
        end
        if (any_gnt_s && (bus.mode == MODE_RR)) begin
            rr_ptr_d = (ptr_inc_s >= CH_W) ? '0 : SEL_W'(ptr_inc_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
    assign bus.out_valid   = out_valid_q;

endmodule
